uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame_if.sv | 24 ++
 rtl/uart_tx_frame.sv | 138 +++++++++++++
 tb/tb_uart_tx_frame.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// Parallel-side handshake and serial line of the UART transmitter.
// The master drives the byte and configuration; the slave (uart_tx_frame) drives the line.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      Data_Valid;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      TX_OUT;
  logic                      Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit(s); Prescale clocks per bit.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_frame #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_frame_if.slave bus
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP_BIT = BIT_CNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e                    state_q,    state_d;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_WIDTH-1:0] presc_q,    presc_d;
  logic [BIT_CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
  logic [DATA_WIDTH-1:0]     data_q,     data_d;
  logic                      par_en_q,   par_en_d;
  logic                      par_typ_q,  par_typ_d;
  logic                      tx_q,       tx_d;
  logic                      busy_q,     busy_d;

  logic [PRESCALE_WIDTH-1:0] edge_last;
  logic                      bit_end;

  // A latched Prescale of zero behaves as one cycle per bit.
  assign edge_last = (presc_q == '0) ? '0 : presc_q - 1'b1;
  assign bit_end   = (edge_cnt_q == edge_last);

  // NOTE: every flop, datapath included, sits on the async reset so an abort leaves no stale frame behind;
  // sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      presc_q    <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      presc_q    <= presc_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  // NOTE: each combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    presc_d    = presc_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;

    if (state_q != IDLE) begin
      edge_cnt_d = bit_end ? '0 : edge_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.Data_Valid) begin
          state_d    = START;
          data_d     = bus.P_DATA;
          par_en_d   = bus.PAR_EN;
          par_typ_d  = bus.PAR_TYP;
          presc_d    = bus.Prescale;
          edge_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == LAST_DATA_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // The bit counter is reused to count stop bits.
        if (bit_end) begin
          if (bit_cnt_q == LAST_STOP_BIT) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from next state so the registered line leads with zero cycles of latency.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_cnt_d];
      PARITY:  tx_d = (^data_d) ^ par_typ_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: frame shape, parity, busy lock-out, Prescale edges, reset abort.
module tb_uart_tx_frame;

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS  = 2;
  localparam int LEN_P4     = 44;
  localparam int LEN_P8_PAR = 96;
  localparam int LEN_P1     = 11;
`else
  localparam int STOP_BITS  = 1;
  localparam int LEN_P4     = 40;
  localparam int LEN_P8_PAR = 88;
  localparam int LEN_P1     = 10;
`endif

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  uart_tx_frame_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(8)) bus ();

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE_WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " tx"},   32'(bus.TX_OUT), 32'd1);
    check({tag, " busy"}, 32'(bus.Busy),   32'd0);
  endtask

  // Called on a falling edge; the request is taken on the following rising edge.
  task automatic start(input logic [7:0] data, input logic pe, input logic pt, input logic [7:0] presc);
    bus.P_DATA     = data;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Prescale   = presc;
    bus.Data_Valid = 1'b1;
    @(negedge clk);
    bus.Data_Valid = 1'b0;
  endtask

  // Walks the frame one falling edge at a time, optionally disturbing the inputs while busy.
  task automatic run_frame(input logic [7:0] data, input logic pe, input logic par_bit,
                           input int p, input int exp_len, input logic noise_dv,
                           input logic [7:0] noise_data, input logic [7:0] noise_presc);
    logic exp_bits[$];
    int   busy_cnt;
    busy_cnt = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(data[i]);
    if (pe) exp_bits.push_back(par_bit);
    for (int s = 0; s < STOP_BITS; s++) exp_bits.push_back(1'b1);
    for (int b = 0; b < exp_bits.size(); b++) begin
      for (int c = 0; c < p; c++) begin
        check($sformatf("frame %02h bit %0d cyc %0d tx", data, b, c), 32'(bus.TX_OUT), 32'(exp_bits[b]));
        if (bus.Busy === 1'b1) busy_cnt++;
        bus.Data_Valid = noise_dv;
        bus.P_DATA     = noise_data;
        bus.Prescale   = noise_presc;
        @(negedge clk);
      end
    end
    bus.Data_Valid = 1'b0;
    check($sformatf("frame %02h busy length", data), 32'(busy_cnt), 32'(exp_len));
    check_idle($sformatf("frame %02h after stop", data));
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    bus.P_DATA     = '0;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Prescale   = '0;

    // Reset, then idle with no request.
    repeat (3) @(negedge clk);
    check_idle("in reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_idle($sformatf("idle %0d", i));
    end

    // Basic frame 0xA5, 4 cycles per bit, no parity.
    start(8'hA5, 1'b0, 1'b0, 8'd4);
    run_frame(8'hA5, 1'b0, 1'b0, 4, LEN_P4, 1'b0, 8'hA5, 8'd4);

    // Parity: 0xA5 holds four ones, so even parity is 0 and odd parity is 1.
    start(8'hA5, 1'b1, 1'b0, 8'd8);
    run_frame(8'hA5, 1'b1, 1'b0, 8, LEN_P8_PAR, 1'b0, 8'hA5, 8'd8);
    start(8'hA5, 1'b1, 1'b1, 8'd8);
    run_frame(8'hA5, 1'b1, 1'b1, 8, LEN_P8_PAR, 1'b0, 8'hA5, 8'd8);

    // Requests for 0x3C throughout a 0xA5 frame, last stop cycle included, are dropped.
    start(8'hA5, 1'b0, 1'b0, 8'd4);
    run_frame(8'hA5, 1'b0, 1'b0, 4, LEN_P4, 1'b1, 8'h3C, 8'd4);
    @(negedge clk);
    check_idle("no second frame");
    start(8'h3C, 1'b0, 1'b0, 8'd4);
    run_frame(8'h3C, 1'b0, 1'b0, 4, LEN_P4, 1'b0, 8'h3C, 8'd4);

    // Prescale 0 and 1 both give one cycle per bit.
    start(8'h5A, 1'b0, 1'b0, 8'd0);
    run_frame(8'h5A, 1'b0, 1'b0, 1, LEN_P1, 1'b0, 8'h5A, 8'd0);
    start(8'h81, 1'b0, 1'b0, 8'd1);
    run_frame(8'h81, 1'b0, 1'b0, 1, LEN_P1, 1'b0, 8'h81, 8'd1);

    // Prescale moved to 16 mid-frame keeps the latched 4 cycles per bit.
    start(8'hC3, 1'b0, 1'b0, 8'd4);
    run_frame(8'hC3, 1'b0, 1'b0, 4, LEN_P4, 1'b0, 8'hC3, 8'd16);

    // Reset during data bit 3 of 0xA5 (cycles 16..19 of the frame), bit value 0.
    start(8'hA5, 1'b0, 1'b0, 8'd4);
    for (int k = 0; k < 17; k++) @(negedge clk);
    check("pre-abort tx",   32'(bus.TX_OUT), 32'd0);
    check("pre-abort busy", 32'(bus.Busy),   32'd1);
    rst_n = 1'b0;
    #1;
    check_idle("async abort");
    repeat (2) @(negedge clk);
    check_idle("held in reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after release");
    start(8'h3C, 1'b0, 1'b0, 8'd4);
    run_frame(8'h3C, 1'b0, 1'b0, 4, LEN_P4, 1'b0, 8'h3C, 8'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
